// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller and its skid
// buffer: the fetch FSM state type, the NOP encoding used as the idle
// instruction, the default reset PC, and a helper that word-aligns a
// branch/jump target.
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  // IDLE only follows reset, REQ owns the memory port, FULL means both the
  // IF/ID output register and the skid entry hold words.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instructions are word aligned, so the low two target bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// One-entry skid buffer that catches a fetched word when the decode stage
// is stalled and the IF/ID output register is already occupied.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   load          : capture load_pc/load_instr, entry becomes valid
//   unload        : entry has been moved to the outputs, becomes empty
//   flush         : discard the entry (redirect); wins over load/unload
//   load_pc       : address of the word being captured
//   load_instr    : word being captured
//   valid/pc/instr: current entry contents
// ---------------------------------------------------------------------------
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Next-entry logic. Flush beats everything because a redirect makes any
  // buffered word stale; pc/instr keep their old contents when emptied.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous reset to an empty NOP entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Entry contents are visible directly from the registers.
  always_comb begin
    valid = valid_q;
    pc    = pc_q;
    instr = instr_q;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller. Issues back-to-back word fetches to the
// instruction memory, presents fetched words to IF/ID, absorbs one extra
// word in a skid buffer when decode stalls, and handles branch redirects
// including a redirect that lands while a request is still in flight.
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   stall            : decode cannot accept; if_* outputs hold
//   redirect_valid   : one-cycle taken branch/jump pulse from EX
//   redirect_pc      : redirect target (low two bits ignored)
//   imem_req         : memory request, high exactly in REQ
//   imem_addr        : fetch address, stable while imem_req is high
//   imem_ready       : current request completes this cycle
//   imem_rdata       : fetched word, valid with imem_ready
//   if_valid         : if_pc/if_instr hold a valid instruction
//   if_pc, if_instr  : instruction handed to IF/ID and its address
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  next_pc_q, next_pc_d;
  logic         drop_q, drop_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;

  logic         skid_load, skid_unload, skid_flush;
  logic         skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  logic         complete;
  logic         out_free;
  logic [31:0]  target;

  // A completion only counts while we actually own the memory port; the
  // output register can take a new word if it is empty or being consumed.
  assign complete = (state_q == REQ) && imem_ready;
  assign out_free = !if_valid_q || !stall;
  assign target   = align_word(redirect_pc);

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (skid_flush),
    .load_pc    (addr_q),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // State register plus all datapath registers. Reset abandons any
  // outstanding request immediately; the memory sees imem_req drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= RESET_PC;
      next_pc_q  <= RESET_PC + 32'd4;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      next_pc_q  <= next_pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Next-state logic. A redirect always lands in REQ so the target gets
  // fetched; FULL is entered only when an undropped word arrives while the
  // output register is occupied and stalled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!redirect_valid && complete && !drop_q && !out_free) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (redirect_valid || !stall) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. A redirect outranks stall and completion. When a
  // request is mid-flight the address must stay put for the memory, so the
  // target parks in next_pc and the returning word is dropped; it then
  // becomes the next fetch through the normal completion path.
  always_comb begin
    addr_d      = addr_q;
    next_pc_d   = next_pc_q;
    drop_d      = drop_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect_valid) begin
      if_valid_d = 1'b0;
      skid_flush = 1'b1;
      if (state_q == REQ && !imem_ready) begin
        next_pc_d = target;
        drop_d    = 1'b1;
      end else begin
        addr_d    = target;
        next_pc_d = target + 32'd4;
        drop_d    = 1'b0;
      end
    end else begin
      if (if_valid_q && !stall) begin
        if_valid_d = 1'b0;
      end
      if (complete) begin
        addr_d    = next_pc_q;
        next_pc_d = next_pc_q + 32'd4;
        drop_d    = 1'b0;
        if (!drop_q) begin
          if (out_free) begin
            if_valid_d = 1'b1;
            if_pc_d    = addr_q;
            if_instr_d = imem_rdata;
          end else begin
            skid_load = 1'b1;
          end
        end
      end else if (state_q == FULL && !stall && skid_valid) begin
        if_valid_d  = 1'b1;
        if_pc_d     = skid_pc;
        if_instr_d  = skid_instr;
        skid_unload = 1'b1;
      end
    end
  end

  // Output logic: the request strobe is a pure decode of the state, the
  // rest come straight from registers.
  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = addr_q;
    if_valid  = if_valid_q;
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A queue-based reference model tracks
// the words waiting for decode (output register first, skid behind it) and
// the fetch address; directed sequences cover reset, stall/skid, redirects
// and PC wrap, followed by a randomized phase checked every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_instr;

  int checks = 0;
  int passed = 0;

  // Reference model: words queued for decode as {pc, instr}, head first.
  logic [63:0] m_q[$];
  bit          m_started;
  logic [31:0] m_addr;
  logic [31:0] m_nxt;
  bit          m_drop;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (hi_req),
    .imem_addr      (hi_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (hi_valid),
    .if_pc          (hi_pc),
    .if_instr       (hi_instr)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advances the reference model by one clock edge with the given inputs.
  // Fetching happens whenever fewer than two words are waiting for decode.
  task automatic modelStep(input logic r, input logic s, input logic rv,
                           input logic [31:0] rp, input logic rdy, input logic [31:0] rd);
    logic [31:0] tgt;
    bit fetching;
    tgt = rp & 32'hFFFF_FFFC;
    fetching = m_started && (m_q.size() < 2);
    if (r) begin
      m_started    = 0;
      m_addr       = 32'h0000_0000;
      m_nxt        = 32'h0000_0004;
      m_drop       = 0;
      m_q.delete();
      m_last_pc    = 32'h0000_0000;
      m_last_instr = 32'h0000_0013;
    end else begin
      if (rv) begin
        m_q.delete();
        if (fetching && !rdy) begin
          m_nxt  = tgt;
          m_drop = 1;
        end else begin
          m_addr = tgt;
          m_nxt  = tgt + 32'd4;
          m_drop = 0;
        end
      end else if (m_started) begin
        if (m_q.size() > 0 && !s) void'(m_q.pop_front());
        if (fetching && rdy) begin
          if (!m_drop) m_q.push_back({m_addr, rd});
          m_drop = 0;
          m_addr = m_nxt;
          m_nxt  = m_nxt + 32'd4;
        end
      end
      m_started = 1;
      if (m_q.size() > 0) begin
        m_last_pc    = m_q[0][63:32];
        m_last_instr = m_q[0][31:0];
      end
    end
  endtask

  // Drives one cycle of inputs, steps the model at the edge, and compares
  // the DUT against the model half a cycle later.
  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rp, input logic rdy);
    logic [31:0] rd;
    rd = $urandom;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ready     = rdy;
    imem_rdata     = rd;
    @(posedge clk);
    modelStep(r, s, rv, rp, rdy, rd);
    @(negedge clk);
    checkOutput("m_imem_req", imem_req, m_started && (m_q.size() < 2));
    checkOutput("m_imem_addr", imem_addr, m_addr);
    checkOutput("m_if_valid", if_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      checkOutput("m_if_pc", if_pc, m_last_pc);
      checkOutput("m_if_instr", if_instr, m_last_instr);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", if_valid, 1'b0);
    checkOutput("rst_pc", if_pc, 32'h0);
    checkOutput("rst_instr", if_instr, 32'h13);

    // Continuous fetch after reset release
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("c1_req", imem_req, 1'b1);
    checkOutput("c1_addr", imem_addr, 32'h0);
    checkOutput("c1_valid", if_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("c2_addr", imem_addr, 32'h4);
    checkOutput("c2_valid", if_valid, 1'b1);
    checkOutput("c2_pc", if_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("c3_addr", imem_addr, 32'h8);
    checkOutput("c3_pc", if_pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("c4_addr", imem_addr, 32'hC);
    checkOutput("c4_pc", if_pc, 32'h8);

    // Stall for three cycles: 0xC goes to skid, requests stop
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("stall_pc", if_pc, 32'h8);
      checkOutput("stall_req", imem_req, 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rel_pc_c", if_pc, 32'hC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rel_pc_10", if_pc, 32'h10);

    // Redirect to 0x100 while the 0x20 request is in flight
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pre_addr_20", imem_addr, 32'h20);
    applyStimulus(0, 0, 1, 32'h100, 0);
    checkOutput("rd_hold_addr", imem_addr, 32'h20);
    checkOutput("rd_valid", if_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("drop_addr", imem_addr, 32'h100);
    checkOutput("drop_valid", if_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tgt_pc", if_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 1);

    // Redirect to 0x203 coinciding with completion and stall
    applyStimulus(0, 1, 1, 32'h203, 1);
    checkOutput("rc_valid", if_valid, 1'b0);
    checkOutput("rc_addr", imem_addr, 32'h200);

    // Reset pulse while a request is outstanding and decode stalls
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pre_rst_req", imem_req, 1'b1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("mid_rst_valid", if_valid, 1'b0);
    checkOutput("mid_rst_instr", if_instr, 32'h13);
    checkOutput("mid_rst_req", imem_req, 1'b0);

    // Post-reset fetch, with PC wrap on the high-reset instance
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("post_rst_req", imem_req, 1'b1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    checkOutput("wrap_addr0", hi_addr, 32'hFFFF_FFF8);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_addr1", hi_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_addr2", hi_addr, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
